// File: rtl/zbus_fifo_pkg.sv
// Shared helpers for the dual-clock zbus FIFO: Gray conversion and parameter checks.
package zbus_fifo_pkg;

  localparam int GW = 32;

  // Bits at and above cnl are ignored, so one function body serves any pointer width.
  function automatic logic [GW-1:0] cnl_mask(input int cnl);
    logic [GW-1:0] m;
    m = '0;
    for (int i = 0; i < GW; i++)
      if (i < cnl) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [GW-1:0] b2g(input logic [GW-1:0] b, input int cnl);
    logic [GW-1:0] bm;
    bm = b & cnl_mask(cnl);
    return bm ^ (bm >> 1);
  endfunction

  function automatic logic [GW-1:0] g2b(input logic [GW-1:0] g, input int cnl);
    logic [GW-1:0] gm;
    logic [GW-1:0] b;
    gm = g & cnl_mask(cnl);
    b  = '0;
    for (int i = 0; i < GW; i++)
      b[i] = ^(gm >> i);
    return b;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/zbus_sync_vec.sv
// SS-stage multi-bit synchroniser; only fed with Gray-coded values so one bit moves per step.
module zbus_sync_vec #(
  parameter int W  = 1,
  parameter int SS = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [SS-1:0][W-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[SS-2:0], i_d};
  end

  assign o_q = r_sync[SS-1];

endmodule

// File: rtl/zbus_fifo_async_reg.sv
// Dual-clock zbus FIFO with Gray pointer crossing and a registered FWFT output stage.
module zbus_fifo_async_reg
  import zbus_fifo_pkg::*;
#(
  parameter int BW  = 8,
  parameter int LN  = 8,
  parameter int SS  = 2,
  parameter int AFT = 1,
  parameter int AET = 1,
  localparam int LNL = $clog2(LN),
  localparam int CNL = LNL + 1
) (
  input  logic           zi_clk,
  input  logic           zi_rst,
  input  logic           zo_clk,
  input  logic           zo_rst,
  input  logic           zi_vld,
  input  logic [BW-1:0]  zi_bus,
  output logic           zi_ack,
  output logic [CNL-1:0] zi_num,
  output logic           zi_afl,
  output logic           zo_vld,
  output logic [BW-1:0]  zo_bus,
  input  logic           zo_ack,
  output logic [CNL-1:0] zo_num,
  output logic           zo_ael
);

  if (!is_pow2(LN) || SS < 2) begin : g_param_chk
    $error("zbus_fifo_async_reg: LN must be a power of two >= 2 and SS >= 2");
  end

  localparam logic [CNL-1:0] LN_C = CNL'(LN);

  logic [BW-1:0]  r_mem [LN];

  // write domain
  logic [CNL-1:0] r_wcb, r_wcg, w_wcb_nxt, w_rcs, w_rcs_bin;
  logic           w_zi_trn;

  // read domain
  logic [CNL-1:0] r_rcb, r_rcg, w_rcb_nxt, w_wcs, w_wcs_bin, w_mcnt;
  logic [BW-1:0]  r_obus;
  logic           r_ovld, w_load;

  zbus_sync_vec #(.W(CNL), .SS(SS)) u_sync_wcg (
    .i_clk (zo_clk), .i_rst (zo_rst), .i_d (r_wcg), .o_q (w_wcs)
  );

  zbus_sync_vec #(.W(CNL), .SS(SS)) u_sync_rcg (
    .i_clk (zi_clk), .i_rst (zi_rst), .i_d (r_rcg), .o_q (w_rcs)
  );

  assign w_rcs_bin = CNL'(g2b(GW'(w_rcs), CNL));
  assign w_wcb_nxt = r_wcb + CNL'(1);
  assign zi_num    = LN_C - (r_wcb - w_rcs_bin);
  assign zi_ack    = (zi_num != '0) & ~zi_rst;
  assign zi_afl    = 32'(zi_num) <= 32'(AFT);
  assign w_zi_trn  = zi_vld & zi_ack;

  always_ff @(posedge zi_clk or posedge zi_rst) begin
    if (zi_rst) begin
      r_wcb <= '0;
      r_wcg <= '0;
    end else if (w_zi_trn) begin
      r_wcb <= w_wcb_nxt;
      r_wcg <= CNL'(b2g(GW'(w_wcb_nxt), CNL));
    end
  end

  // zi_ack is low during reset, so the array needs no reset of its own.
  always_ff @(posedge zi_clk) begin
    if (w_zi_trn) r_mem[r_wcb[LNL-1:0]] <= zi_bus;
  end

  assign w_wcs_bin = CNL'(g2b(GW'(w_wcs), CNL));
  assign w_rcb_nxt = r_rcb + CNL'(1);
  assign w_mcnt    = w_wcs_bin - r_rcb;
  assign w_load    = (w_mcnt != '0) & (~r_ovld | zo_ack);

  // A load frees its memory slot immediately; the output register holds the word.
  always_ff @(posedge zo_clk or posedge zo_rst) begin
    if (zo_rst) begin
      r_rcb  <= '0;
      r_rcg  <= '0;
      r_obus <= '0;
      r_ovld <= 1'b0;
    end else if (w_load) begin
      r_obus <= r_mem[r_rcb[LNL-1:0]];
      r_ovld <= 1'b1;
      r_rcb  <= w_rcb_nxt;
      r_rcg  <= CNL'(b2g(GW'(w_rcb_nxt), CNL));
    end else if (zo_ack) begin
      r_ovld <= 1'b0;
    end
  end

  assign zo_vld = r_ovld;
  assign zo_bus = r_obus;
  assign zo_num = w_mcnt + CNL'(r_ovld);
  assign zo_ael = 32'(zo_num) <= 32'(AET);

endmodule

// File: tb/tb_zbus_fifo_async_reg.sv
// Directed bench for zbus_fifo_async_reg with LN=4, SS=2: reset, latency, full, wrap, mid-reset.
`timescale 1ns/1ps
module tb_zbus_fifo_async_reg;

  localparam int BW = 8, LN = 4, SS = 2, AFT = 1, AET = 1, CNL = 3;

  logic           zi_clk = 1'b0, zo_clk = 1'b0;
  logic           zi_rst, zo_rst, zi_vld, zo_ack;
  logic [BW-1:0]  zi_bus;
  logic           zi_ack, zi_afl, zo_vld, zo_ael;
  logic [CNL-1:0] zi_num, zo_num;
  logic [BW-1:0]  zo_bus;

  int zo_half = 6;
  int checks  = 0;
  int errors  = 0;

  always #6 zi_clk = ~zi_clk;
  always #(zo_half) zo_clk = ~zo_clk;

  zbus_fifo_async_reg #(.BW(BW), .LN(LN), .SS(SS), .AFT(AFT), .AET(AET)) dut (
    .zi_clk (zi_clk), .zi_rst (zi_rst), .zo_clk (zo_clk), .zo_rst (zo_rst),
    .zi_vld (zi_vld), .zi_bus (zi_bus), .zi_ack (zi_ack), .zi_num (zi_num),
    .zi_afl (zi_afl), .zo_vld (zo_vld), .zo_bus (zo_bus), .zo_ack (zo_ack),
    .zo_num (zo_num), .zo_ael (zo_ael)
  );

  task automatic test_reset();
    zi_rst = 1'b1; zo_rst = 1'b1; zi_vld = 1'b0; zo_ack = 1'b0; zi_bus = '0;
    repeat (3) @(negedge zi_clk);
    checks++; if (zi_ack !== 1'b0)   begin errors++; $display("FAIL rst_zi_ack got %0h exp 0", zi_ack); end
    checks++; if (zi_num !== 3'd4)   begin errors++; $display("FAIL rst_zi_num got %0d exp 4", zi_num); end
    checks++; if (zi_afl !== 1'b0)   begin errors++; $display("FAIL rst_zi_afl got %0h exp 0", zi_afl); end
    checks++; if (zo_vld !== 1'b0)   begin errors++; $display("FAIL rst_zo_vld got %0h exp 0", zo_vld); end
    checks++; if (zo_num !== 3'd0)   begin errors++; $display("FAIL rst_zo_num got %0d exp 0", zo_num); end
    checks++; if (zo_ael !== 1'b1)   begin errors++; $display("FAIL rst_zo_ael got %0h exp 1", zo_ael); end
    checks++; if (zo_bus !== 8'h00)  begin errors++; $display("FAIL rst_zo_bus got %0h exp 0", zo_bus); end
    zi_rst = 1'b0;
    @(negedge zo_clk); zo_rst = 1'b0;
    @(negedge zi_clk);
    checks++; if (zi_ack !== 1'b1)   begin errors++; $display("FAIL rel_zi_ack got %0h exp 1", zi_ack); end
    checks++; if (zi_num !== 3'd4)   begin errors++; $display("FAIL rel_zi_num got %0d exp 4", zi_num); end
  endtask

  task automatic test_latency();
    int k;
    bit found;
    @(negedge zi_clk);
    zi_vld = 1'b1; zi_bus = 8'hA5;
    @(posedge zi_clk);
    @(negedge zi_clk);
    zi_vld = 1'b0;
    k = 0; found = 1'b0;
    while (!found && k < 6) begin
      @(posedge zo_clk); #1;
      k++;
      found = zo_vld;
    end
    checks++; if (!found || k < 3 || k > 4) begin errors++; $display("FAIL lat_edges got %0d exp 3..4", k); end
    checks++; if (zo_bus !== 8'hA5) begin errors++; $display("FAIL lat_zo_bus got %0h exp a5", zo_bus); end
    checks++; if (zo_num !== 3'd1)  begin errors++; $display("FAIL lat_zo_num got %0d exp 1", zo_num); end
    checks++; if (zo_ael !== 1'b1)  begin errors++; $display("FAIL lat_zo_ael got %0h exp 1", zo_ael); end
    @(negedge zo_clk); zo_ack = 1'b1;
    @(negedge zo_clk); zo_ack = 1'b0;
    checks++; if (zo_vld !== 1'b0)  begin errors++; $display("FAIL lat_drain_vld got %0h exp 0", zo_vld); end
    checks++; if (zo_bus !== 8'hA5) begin errors++; $display("FAIL lat_hold_bus got %0h exp a5", zo_bus); end
  endtask

  task automatic test_fill();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int g;
    @(negedge zi_clk);
    for (int i = 0; i < 4; i++) begin
      zi_vld = 1'b1; zi_bus = vals[i];
      checks++; if (zi_ack !== 1'b1) begin errors++; $display("FAIL fill_ack[%0d] got %0h exp 1", i, zi_ack); end
      checks++; if (zi_num !== 3'(4 - i)) begin errors++; $display("FAIL fill_num[%0d] got %0d exp %0d", i, zi_num, 4 - i); end
      checks++; if (zi_afl !== ((4 - i) <= 1)) begin errors++; $display("FAIL fill_afl[%0d] got %0h", i, zi_afl); end
      @(negedge zi_clk);
    end
    zi_bus = 8'h55;
    checks++; if (zi_num !== 3'd0) begin errors++; $display("FAIL full_num got %0d exp 0", zi_num); end
    checks++; if (zi_afl !== 1'b1) begin errors++; $display("FAIL full_afl got %0h exp 1", zi_afl); end
    checks++; if (zi_ack !== 1'b0) begin errors++; $display("FAIL full_ack got %0h exp 0", zi_ack); end
    @(negedge zi_clk);
    checks++; if (zi_ack !== 1'b0) begin errors++; $display("FAIL full_hold_ack got %0h exp 0", zi_ack); end
    // The slot freed by loading 0x11 into the output register comes back after sync.
    g = 0;
    while (!zi_ack && g < 10) begin @(negedge zi_clk); g++; end
    checks++; if (zi_ack !== 1'b1) begin errors++; $display("FAIL fill_55_ack got %0h exp 1", zi_ack); end
    @(negedge zi_clk);
    zi_vld = 1'b0;
    repeat (4) @(negedge zi_clk);
    checks++; if (zi_num !== 3'd0)  begin errors++; $display("FAIL fill_end_num got %0d exp 0", zi_num); end
    checks++; if (zo_vld !== 1'b1)  begin errors++; $display("FAIL fill_zo_vld got %0h exp 1", zo_vld); end
    checks++; if (zo_bus !== 8'h11) begin errors++; $display("FAIL fill_zo_bus got %0h exp 11", zo_bus); end
    checks++; if (zo_num !== 3'd5)  begin errors++; $display("FAIL fill_zo_num got %0d exp 5", zo_num); end
    checks++; if (zo_ael !== 1'b0)  begin errors++; $display("FAIL fill_zo_ael got %0h exp 0", zo_ael); end
  endtask

  task automatic test_full_traffic();
    logic [7:0] expv [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int cnt, got, g;
    @(negedge zi_clk);
    zi_vld = 1'b1; zi_bus = 8'h66;
    checks++; if (zi_ack !== 1'b0) begin errors++; $display("FAIL ft_ack_pre got %0h exp 0", zi_ack); end
    @(negedge zo_clk); zo_ack = 1'b1;
    @(negedge zo_clk); zo_ack = 1'b0;
    checks++; if (zo_bus !== 8'h22) begin errors++; $display("FAIL ft_reload got %0h exp 22", zo_bus); end
    cnt = 0;
    while (!zi_ack && cnt < 8) begin @(negedge zi_clk); cnt++; end
    checks++; if (zi_ack !== 1'b1 || cnt > 4) begin errors++; $display("FAIL ft_ack_ret got %0d edges exp <=4", cnt); end
    @(negedge zi_clk);
    zi_vld = 1'b0;
    zo_ack = 1'b1;
    got = 0; g = 0;
    while (got < 5 && g < 40) begin
      if (zo_vld) begin
        checks++; if (zo_bus !== expv[got]) begin errors++; $display("FAIL ft_drain[%0d] got %0h exp %0h", got, zo_bus, expv[got]); end
        got++;
      end
      @(negedge zo_clk);
      g++;
    end
    zo_ack = 1'b0;
    checks++; if (got != 5) begin errors++; $display("FAIL ft_drain_cnt got %0d exp 5", got); end
    repeat (6) @(negedge zi_clk);
    checks++; if (zo_vld !== 1'b0)  begin errors++; $display("FAIL empty_vld got %0h exp 0", zo_vld); end
    checks++; if (zo_num !== 3'd0)  begin errors++; $display("FAIL empty_num got %0d exp 0", zo_num); end
    checks++; if (zo_ael !== 1'b1)  begin errors++; $display("FAIL empty_ael got %0h exp 1", zo_ael); end
    checks++; if (zo_bus !== 8'h66) begin errors++; $display("FAIL empty_hold got %0h exp 66", zo_bus); end
    checks++; if (zi_num !== 3'd4)  begin errors++; $display("FAIL empty_zi_num got %0d exp 4", zi_num); end
  endtask

  task automatic test_stream(input int half);
    int rexp;
    zo_half = half;
    repeat (2) @(negedge zo_clk);
    rexp = 0;
    fork
      begin
        @(negedge zi_clk);
        for (int i = 0; i < 40; i++) begin
          int g;
          zi_vld = 1'b1; zi_bus = 8'(i);
          g = 0;
          while (!zi_ack && g < 500) begin @(negedge zi_clk); g++; end
          if (!zi_ack) begin
            checks++; errors++;
            $display("FAIL stream_wr_timeout half=%0d word %0d", half, i);
            break;
          end
          @(negedge zi_clk);
        end
        zi_vld = 1'b0;
      end
      begin
        int g;
        g = 0;
        while (rexp < 40 && g < 3000) begin
          zo_ack = 1'($urandom_range(0, 1));
          if (zo_vld && zo_ack) begin
            checks++; if (zo_bus !== 8'(rexp)) begin errors++; $display("FAIL stream half=%0d got %0h exp %0h", half, zo_bus, rexp); end
            rexp++;
          end
          @(negedge zo_clk);
          g++;
        end
        zo_ack = 1'b0;
      end
    join
    checks++; if (rexp != 40) begin errors++; $display("FAIL stream_cnt half=%0d got %0d exp 40", half, rexp); end
    repeat (8) @(negedge zo_clk);
    checks++; if (zo_vld !== 1'b0) begin errors++; $display("FAIL stream_dup half=%0d zo_vld got %0h exp 0", half, zo_vld); end
  endtask

  task automatic test_midreset();
    logic [7:0] vals [3] = '{8'h01, 8'h02, 8'h03};
    int g;
    @(negedge zi_clk);
    for (int i = 0; i < 3; i++) begin
      zi_vld = 1'b1; zi_bus = vals[i];
      g = 0;
      while (!zi_ack && g < 20) begin @(negedge zi_clk); g++; end
      @(negedge zi_clk);
    end
    zi_vld = 1'b0;
    g = 0;
    while (!zo_vld && g < 20) begin @(negedge zo_clk); g++; end
    checks++; if (zo_vld !== 1'b1) begin errors++; $display("FAIL mr_pre_vld got %0h exp 1", zo_vld); end
    #3;
    zi_rst = 1'b1; zo_rst = 1'b1;
    #1;
    checks++; if (zo_vld !== 1'b0)  begin errors++; $display("FAIL mr_vld got %0h exp 0", zo_vld); end
    checks++; if (zo_num !== 3'd0)  begin errors++; $display("FAIL mr_zo_num got %0d exp 0", zo_num); end
    checks++; if (zi_num !== 3'd4)  begin errors++; $display("FAIL mr_zi_num got %0d exp 4", zi_num); end
    checks++; if (zi_ack !== 1'b0)  begin errors++; $display("FAIL mr_zi_ack got %0h exp 0", zi_ack); end
    checks++; if (zo_bus !== 8'h00) begin errors++; $display("FAIL mr_zo_bus got %0h exp 0", zo_bus); end
    repeat (3) @(negedge zi_clk);
    zi_rst = 1'b0;
    @(negedge zo_clk); zo_rst = 1'b0;
    repeat (6) @(negedge zi_clk);
    checks++; if (zo_vld !== 1'b0) begin errors++; $display("FAIL mr_post_vld got %0h exp 0", zo_vld); end
    checks++; if (zi_num !== 3'd4) begin errors++; $display("FAIL mr_post_num got %0d exp 4", zi_num); end
    checks++; if (zi_ack !== 1'b1) begin errors++; $display("FAIL mr_post_ack got %0h exp 1", zi_ack); end
    zi_vld = 1'b1; zi_bus = 8'h99;
    @(negedge zi_clk);
    zi_vld = 1'b0;
    g = 0;
    while (!zo_vld && g < 20) begin @(negedge zo_clk); g++; end
    checks++; if (zo_vld !== 1'b1)  begin errors++; $display("FAIL mr_99_vld got %0h exp 1", zo_vld); end
    checks++; if (zo_bus !== 8'h99) begin errors++; $display("FAIL mr_99_bus got %0h exp 99", zo_bus); end
    checks++; if (zo_num !== 3'd1)  begin errors++; $display("FAIL mr_99_num got %0d exp 1", zo_num); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_full_traffic();
    test_stream(2);
    test_stream(18);
    test_stream(6);
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
